// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the register file slice:
//   REGFILE_WIDTH - default data width of one register
//   REGFILE_DEPTH - default number of registers
//   REG_ZERO      - address of the hardwired-zero register
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int unsigned REGFILE_WIDTH = 64;
  localparam int unsigned REGFILE_DEPTH = 32;
  localparam int unsigned REG_ZERO      = 0;

endpackage : regfile_pkg

// File: rtl/d_register.sv
// -----------------------------------------------------------------------------
// d_register
// One WIDTH-bit enabled D register with asynchronous active-high reset.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, clears the register to 0
//   en_i - load enable; when low the register holds
//   d_i  - data to load
//   q_o  - registered value
// -----------------------------------------------------------------------------
module d_register #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule : d_register

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
// DEPTH x WIDTH register file, one write port and two combinational read
// ports. Entry 0 is hardwired to zero.
// Ports:
//   clk      - clock, all writes on rising edge
//   rst      - asynchronous active-high reset, clears every entry
//   wr_en    - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr1 - read port 1 address
//   rd_data1 - read port 1 data (combinational)
//   rd_addr2 - read port 2 address
//   rd_data2 - read port 2 data (combinational)
// Configuration macro:
//   REGFILE_BYPASS_EN - when defined, a same-cycle write to a nonzero address
//                       is forwarded to any read port addressing it.
// -----------------------------------------------------------------------------
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = REGFILE_WIDTH,
  parameter int unsigned DEPTH = REGFILE_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data2
);

  logic [WIDTH-1:0] regs [DEPTH];

  // Entry 0 is a constant, so writes to it vanish and reads see 0.
  assign regs[REG_ZERO] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_entry
    logic sel;
    assign sel = wr_en && (wr_addr == AW'(i));

    d_register #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk  (clk),
      .rst  (rst),
      .en_i (sel),
      .d_i  (wr_data),
      .q_o  (regs[i])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = !rst && wr_en && (wr_addr != AW'(REG_ZERO));
`endif

  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_data2 = regs[rd_addr2];
`ifdef REGFILE_BYPASS_EN
    if (fwd_ok && (rd_addr1 == wr_addr)) begin
      rd_data1 = wr_data;
    end
    if (fwd_ok && (rd_addr2 == wr_addr)) begin
      rd_data2 = wr_data;
    end
`endif
  end

endmodule : regfile

// File: tb/tb_regfile.sv
module tb_regfile;

  localparam int unsigned W  = 64;
  localparam int unsigned D  = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [AW-1:0] rd_addr1 = '0;
  logic [W-1:0]  rd_data1;
  logic [AW-1:0] rd_addr2 = '0;
  logic [W-1:0]  rd_data2;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mdl [D];

  regfile #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1),
    .rd_addr2 (rd_addr2),
    .rd_data2 (rd_data2)
  );

  always #50 clk = ~clk;

  // Single write: driven at negedge, committed at the following posedge.
  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] v);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = v;
    @(posedge clk);
    #1;
    if (a != 0) mdl[a] = v;
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    // Held reset from time 0: every entry reads 0.
    #10;
    rd_addr1 = 5'd1; rd_addr2 = 5'd31;
    #1;
    checks++;
    if (rd_data1 !== 64'h0) begin errors++; $display("FAIL reset_init_p1 got %h exp %h", rd_data1, 64'h0); end
    checks++;
    if (rd_data2 !== 64'h0) begin errors++; $display("FAIL reset_init_p2 got %h exp %h", rd_data2, 64'h0); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < D; i++) mdl[i] = '0;
    // Fill every address with 0xDEAD back to back.
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 64'hDEAD;
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_addr1 = 5'd1; rd_addr2 = 5'd31;
    #1;
    checks++;
    if (rd_data1 !== 64'hDEAD) begin errors++; $display("FAIL fill_a1 got %h exp %h", rd_data1, 64'hDEAD); end
    checks++;
    if (rd_data2 !== 64'hDEAD) begin errors++; $display("FAIL fill_a31 got %h exp %h", rd_data2, 64'hDEAD); end
    rd_addr1 = 5'd0;
    #1;
    checks++;
    if (rd_data1 !== 64'h0) begin errors++; $display("FAIL fill_a0 got %h exp %h", rd_data1, 64'h0); end
    // Assert rst mid-cycle and scan all addresses before the next rising edge.
    @(negedge clk);
    #10;
    rst = 1'b1;
    for (int i = 0; i < D / 2; i++) begin
      rd_addr1 = AW'(i); rd_addr2 = AW'(D - 1 - i);
      #2;
      checks++;
      if (rd_data1 !== 64'h0) begin errors++; $display("FAIL async_clr_p1 addr %0d got %h exp %h", i, rd_data1, 64'h0); end
      checks++;
      if (rd_data2 !== 64'h0) begin errors++; $display("FAIL async_clr_p2 addr %0d got %h exp %h", D - 1 - i, rd_data2, 64'h0); end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < D; i++) mdl[i] = '0;
  endtask

  task automatic test_write_read;
    do_write(5'd5, 64'h1234);
    rd_addr1 = 5'd5; rd_addr2 = 5'd5;
    #1;
    checks++;
    if (rd_data1 !== 64'h1234) begin errors++; $display("FAIL wr_rd_p1 got %h exp %h", rd_data1, 64'h1234); end
    checks++;
    if (rd_data2 !== 64'h1234) begin errors++; $display("FAIL wr_rd_p2 got %h exp %h", rd_data2, 64'h1234); end
    // Independent ports on different addresses.
    do_write(5'd6, 64'hCAFE_F00D_0000_0001);
    rd_addr1 = 5'd6; rd_addr2 = 5'd5;
    #1;
    checks++;
    if (rd_data1 !== 64'hCAFE_F00D_0000_0001) begin errors++; $display("FAIL indep_p1 got %h exp %h", rd_data1, 64'hCAFE_F00D_0000_0001); end
    checks++;
    if (rd_data2 !== 64'h1234) begin errors++; $display("FAIL indep_p2 got %h exp %h", rd_data2, 64'h1234); end
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'hFFFF;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    #1;
    checks++;
    if (rd_data1 !== 64'h0) begin errors++; $display("FAIL zero_same_cycle got %h exp %h", rd_data1, 64'h0); end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    checks++;
    if (rd_data1 !== 64'h0) begin errors++; $display("FAIL zero_p1 got %h exp %h", rd_data1, 64'h0); end
    checks++;
    if (rd_data2 !== 64'h0) begin errors++; $display("FAIL zero_p2 got %h exp %h", rd_data2, 64'h0); end
  endtask

  task automatic test_hold;
    do_write(5'd7, 64'hAA);
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 5'd7; wr_data = 64'h55;
    @(posedge clk);
    #1;
    rd_addr1 = 5'd7;
    #1;
    checks++;
    if (rd_data1 !== 64'hAA) begin errors++; $display("FAIL hold got %h exp %h", rd_data1, 64'hAA); end
  endtask

  task automatic test_hazard;
    logic [W-1:0] exp_before;
`ifdef REGFILE_BYPASS_EN
    exp_before = 64'h20;
`else
    exp_before = 64'h10;
`endif
    do_write(5'd3, 64'h10);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h20;
    rd_addr1 = 5'd3; rd_addr2 = 5'd3;
    #1;
    checks++;
    if (rd_data1 !== exp_before) begin errors++; $display("FAIL hazard_pre_p1 got %h exp %h", rd_data1, exp_before); end
    checks++;
    if (rd_data2 !== exp_before) begin errors++; $display("FAIL hazard_pre_p2 got %h exp %h", rd_data2, exp_before); end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    mdl[3] = 64'h20;
    checks++;
    if (rd_data1 !== 64'h20) begin errors++; $display("FAIL hazard_post got %h exp %h", rd_data1, 64'h20); end
  endtask

  task automatic test_reset_priority;
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h77;
    rd_addr1 = 5'd9;
    #1;
    checks++;
    if (rd_data1 !== 64'h0) begin errors++; $display("FAIL rst_no_fwd got %h exp %h", rd_data1, 64'h0); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < D; i++) mdl[i] = '0;
    #1;
    checks++;
    if (rd_data1 !== 64'h0) begin errors++; $display("FAIL rst_prio got %h exp %h", rd_data1, 64'h0); end
    // First enabled edge after release performs a normal write.
    do_write(5'd9, 64'h99);
    checks++;
    if (rd_data1 !== 64'h99) begin errors++; $display("FAIL post_rst_write got %h exp %h", rd_data1, 64'h99); end
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] addrs [4];
    logic [W-1:0]  vals  [4];
    addrs = '{5'd1, 5'd2, 5'd30, 5'd31};
    vals  = '{64'h1111_0000_0000_0001, 64'h2222, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = addrs[k]; wr_data = vals[k];
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 4; k++) mdl[addrs[k]] = vals[k];
    // Full scan: written entries hold their data, nothing else disturbed.
    for (int i = 0; i < D; i++) begin
      rd_addr1 = AW'(i); rd_addr2 = AW'(D - 1 - i);
      #1;
      checks++;
      if (rd_data1 !== mdl[i]) begin errors++; $display("FAIL scan_p1 addr %0d got %h exp %h", i, rd_data1, mdl[i]); end
      checks++;
      if (rd_data2 !== mdl[D - 1 - i]) begin errors++; $display("FAIL scan_p2 addr %0d got %h exp %h", D - 1 - i, rd_data2, mdl[D - 1 - i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) mdl[i] = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_hold();
    test_hazard();
    test_reset_priority();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule : tb_regfile

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter WIDTH, default 64: data width of each register in bits.
REQ-002 Parameter DEPTH, default 32: number of registers; power of two, minimum 2.
REQ-003 Parameter AW, default $clog2(DEPTH): address width; derived, not overridden.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 wr_en  input  1  write enable, sampled on rising clk.
REQ-007 wr_addr  input  AW  write address.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 rd_addr1  input  AW  read port 1 address.
REQ-010 rd_data1  output  WIDTH  read port 1 data.
REQ-011 rd_addr2  input  AW  read port 2 address.
REQ-012 rd_data2  output  WIDTH  read port 2 data.

Function
REQ-013 Storage SHALL be DEPTH registers of WIDTH bits, each an enabled D register.
REQ-014 Reads SHALL be combinational, zero latency: rd_dataN = reg[rd_addrN] in the same cycle.
REQ-015 A write SHALL occur on a rising clk when wr_en=1 and rst=0: reg[wr_addr] <= wr_data; the new value is visible on reads after that edge.
REQ-016 wr_en=0 SHALL leave every register unchanged, whatever wr_addr/wr_data are (hold, as in an enabled flip-flop).
REQ-017 Register 0 SHALL be hardwired zero: writes to address 0 are discarded; reads of address 0 return 0 on both ports.
REQ-018 Both read ports SHALL be independent; same address on both ports returns identical data.
REQ-019 Read and write to the same nonzero address in one cycle SHALL return the old value, unless REGFILE_BYPASS_EN is defined (REQ-024).
REQ-020 Only one register SHALL change per clock edge; no other entry is disturbed.

Reset
REQ-021 rst=1 SHALL clear every register to 0 immediately, without waiting for clk; rd_data1/rd_data2 read 0 while rst is held.
REQ-022 rst SHALL override wr_en: a write coinciding with an asserted rst is lost.
REQ-023 After rst deasserts, the first rising clk with wr_en=1 SHALL perform a normal write.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN. When defined: if wr_en=1, wr_addr!=0, and rd_addrN==wr_addr, then rd_dataN = wr_data combinationally in the same cycle (write-to-read forwarding). The address-0 rule still applies. Forwarding is suppressed while rst=1. When undefined: no forwarding, reads return stored contents only.

Structure
REQ-025 Package regfile_pkg SHALL hold the default WIDTH/DEPTH constants and the zero-register address constant (REG_ZERO = 0).
REQ-026 Sub-module d_register SHALL implement one WIDTH-bit register with clk, async active-high rst, enable, D and Q. regfile instantiates DEPTH-1 copies through a generate loop; entry 0 is a constant.

Verification
REQ-027 Reset: write 0xDEAD to every address, assert rst mid-cycle -> all reads return 0 before the next clk edge.
REQ-028 Write/read: wr_en=1, wr_addr=5, wr_data=0x1234 -> rd_addr1=5 reads 0x1234 after the edge; rd_addr2=5 matches.
REQ-029 Zero register: write 0xFFFF to address 0 -> both ports read 0 at address 0.
REQ-030 Hold: address 7 holds 0xAA; wr_en=0, wr_addr=7, wr_data=0x55 -> address 7 still reads 0xAA.
REQ-031 Same-cycle hazard: address 3 holds 0x10; write 0x20 to address 3 while reading 3 -> reads 0x10 before the edge without REGFILE_BYPASS_EN, 0x20 with it; 0x20 after the edge in both builds.
REQ-032 Reset priority: rst=1 with wr_en=1, wr_addr=9, wr_data=0x77 -> address 9 reads 0 after the rst is released.
